// File: rtl/usc_rv_fetch_queue.sv
// usc_rv_fetch_queue: circular fetch queue between IF and decode.
// Packets of LANES instructions go in compacted; up to LANES head entries come out in order.
// Ports: clk_i, rst_i (sync, active-high), flush_i
//   push_i/push_vld_i/push_pc_i/push_instr_i/push_pred_i/push_info_i -> accept_o
//   out_valid_o/out_pc_o/out_instr_o/out_pred_o/out_info_o, pop_i, level_o
// Option: define USC_RV_FQ_BYPASS_EN to forward pushes straight to out_* when empty.
module usc_rv_fetch_queue #(
  parameter int LANES  = 2,
  parameter int DEPTH  = 8,
  parameter int INFO_W = 10
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      push_i,
  input  logic [LANES-1:0]          push_vld_i,
  input  logic [31:0]               push_pc_i,
  input  logic [32*LANES-1:0]       push_instr_i,
  input  logic [LANES-1:0]          push_pred_i,
  input  logic [INFO_W*LANES-1:0]   push_info_i,
  output logic                      accept_o,
  output logic [LANES-1:0]          out_valid_o,
  output logic [32*LANES-1:0]       out_pc_o,
  output logic [32*LANES-1:0]       out_instr_o,
  output logic [LANES-1:0]          out_pred_o,
  output logic [INFO_W*LANES-1:0]   out_info_o,
  input  logic [LANES-1:0]          pop_i,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [31:0]       pc_q    [DEPTH];
  logic [31:0]       instr_q [DEPTH];
  logic              pred_q  [DEPTH];
  logic [INFO_W-1:0] info_q  [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [LW-1:0] level;

  logic [LW-1:0] pos [LANES];
  logic [LW-1:0] n_vld;
  logic [LW-1:0] n_pop;
  logic [LW-1:0] n_wr;
  logic [LW-1:0] n_rd;
  logic [LW-1:0] skip;
  logic [PW-1:0] widx [LANES];
  logic          do_push;
  logic          byp;
  logic          run;

  // Compacted slot of each valid lane = number of valid lanes below it.
  always_comb begin
    n_vld = '0;
    for (int k = 0; k < LANES; k++) begin
      pos[k] = n_vld;
      n_vld  = n_vld + LW'(push_vld_i[k]);
    end
  end

  assign accept_o = !rst_i && (level <= LW'(DEPTH-LANES));
  assign do_push  = push_i && accept_o && !flush_i;
  assign level_o  = rst_i ? '0 : level;

`ifdef USC_RV_FQ_BYPASS_EN
  assign byp = do_push && (level == '0);
`else
  assign byp = 1'b0;
`endif

  always_comb begin
    out_valid_o = '0;
    out_pc_o    = '0;
    out_instr_o = '0;
    out_pred_o  = '0;
    out_info_o  = '0;
    if (!rst_i) begin
      for (int j = 0; j < LANES; j++) begin
        if (byp) begin
          for (int k = 0; k < LANES; k++) begin
            if (push_vld_i[k] && pos[k] == LW'(j)) begin
              out_valid_o[j]            = 1'b1;
              out_pc_o[32*j +: 32]      = push_pc_i + (32'(k) << 2);
              out_instr_o[32*j +: 32]   = push_instr_i[32*k +: 32];
              out_pred_o[j]             = push_pred_i[k];
              out_info_o[INFO_W*j +: INFO_W] = push_info_i[INFO_W*k +: INFO_W];
            end
          end
        end else if (level > LW'(j)) begin
          out_valid_o[j]          = 1'b1;
          out_pc_o[32*j +: 32]    = pc_q[rd_ptr + PW'(j)];
          out_instr_o[32*j +: 32] = instr_q[rd_ptr + PW'(j)];
          out_pred_o[j]           = pred_q[rd_ptr + PW'(j)];
          out_info_o[INFO_W*j +: INFO_W] = info_q[rd_ptr + PW'(j)];
        end
      end
    end
  end

  // Pop only the unbroken run of consumed lanes from lane 0.
  always_comb begin
    n_pop = '0;
    run   = 1'b1;
    for (int j = 0; j < LANES; j++) begin
      if (run && pop_i[j] && out_valid_o[j]) n_pop = n_pop + 1'b1;
      else run = 1'b0;
    end
  end

  // In bypass, popped lanes never reach storage.
  always_comb begin
    skip = byp ? n_pop : '0;
    n_rd = byp ? '0 : n_pop;
    n_wr = do_push ? (n_vld - skip) : '0;
    for (int k = 0; k < LANES; k++)
      widx[k] = wr_ptr + PW'(pos[k] - skip);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(n_rd);
      wr_ptr <= wr_ptr + PW'(n_wr);
      level  <= level + n_wr - n_rd;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      for (int k = 0; k < LANES; k++) begin
        if (push_vld_i[k] && pos[k] >= skip) begin
          pc_q[widx[k]]    <= push_pc_i + (32'(k) << 2);
          instr_q[widx[k]] <= push_instr_i[32*k +: 32];
          pred_q[widx[k]]  <= push_pred_i[k];
          info_q[widx[k]]  <= push_info_i[INFO_W*k +: INFO_W];
        end
      end
    end
  end

endmodule
